imem_fetch_unit: RTL
====================

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Ports SHALL be, clock and reset first: clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk.
REQ-003 PCF  in  32  fetch address from the program counter; byte address.
REQ-004 HoldF  in  1  core fetch-stage stall from the hazard unit; 1 = do not hand over a new instruction.
REQ-005 RedirectF  in  1  branch/jump taken; 1 = in-flight and held fetches are stale; PCF already carries the new target.
REQ-006 InstrF  out  32  instruction to the fetch/decode pipeline register.
REQ-007 InstrValidF  out  1  1 = InstrF is valid this cycle.
REQ-008 FetchStallF  out  1  equals ~InstrValidF; the PC SHALL advance only when FetchStallF=0 and HoldF=0.
REQ-009 FetchErrF  out  1  1 = InstrF is a substituted NOP caused by a bus error or a misaligned PCF.
REQ-010 imem_req  out  1  memory request valid.
REQ-011 imem_addr  out  32  request address; equals PCF whenever imem_req=1.
REQ-012 imem_gnt  in  1  request accepted in the cycle imem_req&imem_gnt.
REQ-013 imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-014 imem_rdata  in  32  response data; imem_err  in  1  response error, qualified by imem_rvalid.

Function
REQ-015 FSM states SHALL be REQ, RSP, HOLD; reset state REQ.
REQ-016 REQ: imem_req=1 unless PCF[1:0]!=0, RedirectF=1, or DiscardCnt=2; on imem_req&imem_gnt go to RSP.
REQ-017 REQ with PCF[1:0]!=0 and RedirectF=0: no request; InstrF=32'h00000013, InstrValidF=1, FetchErrF=1; stay in REQ.
REQ-018 RSP: imem_rvalid with DiscardCnt=0 SHALL deliver in the same cycle: InstrF=imem_rdata (32'h00000013 if imem_err), InstrValidF=1, FetchErrF=imem_err.
REQ-019 After a delivery in RSP: HoldF=0 -> REQ; HoldF=1 -> capture InstrF/FetchErrF into a hold register and go to HOLD.
REQ-020 HOLD: present the hold register with InstrValidF=1 every cycle; when HoldF=0 go to REQ next cycle.
REQ-021 Minimum throughput with zero-wait memory (gnt immediately, rvalid next cycle) SHALL be one instruction per 2 cycles.
REQ-022 DiscardCnt (2-bit, range 0..2) SHALL count stale outstanding responses; imem_rvalid with DiscardCnt>0 decrements it, is dropped, and produces InstrValidF=0.
REQ-023 RedirectF in RSP without imem_rvalid: DiscardCnt+1, go to REQ. RedirectF in RSP with imem_rvalid and DiscardCnt=0: drop the response, DiscardCnt unchanged, go to REQ.
REQ-024 RedirectF in HOLD: discard the hold register, InstrValidF=0 that cycle, go to REQ.
REQ-025 RedirectF in REQ: no request issued that cycle; FSM stays in REQ.
REQ-026 RedirectF SHALL override HoldF in every state.
REQ-027 A response arriving in REQ with DiscardCnt=0 is a protocol violation; it SHALL be ignored.
REQ-028 Outstanding requests (DiscardCnt plus a live request in RSP) SHALL never exceed 2.

Reset
REQ-029 While reset=0: state=REQ, DiscardCnt=0, hold register=32'h00000013, imem_req=0, InstrValidF=0, FetchStallF=1, FetchErrF=0, InstrF=32'h00000013.
REQ-030 Reset asserted mid-transaction SHALL abandon all outstanding requests.
REQ-031 Responses arriving in the first cycles after reset release SHALL NOT be delivered; DiscardCnt=0 in REQ applies (REQ-027).

Verification
REQ-032 Zero-wait stream, PCF=0,4,8 with HoldF=0 -> three requests; InstrValidF high every 2nd cycle; InstrF matches memory at 0, 4, 8.
REQ-033 Response for PCF=0x10 with HoldF=1 for 3 cycles -> InstrF held stable with InstrValidF=1 for 4 cycles; next request for 0x14 issued the cycle after HoldF falls.
REQ-034 Grant at 0x20, RedirectF in RSP, PCF=0x80 -> old response dropped (DiscardCnt 1->0); only the 0x80 instruction is delivered.
REQ-035 rvalid with imem_err=1 at 0x30 -> InstrF=32'h00000013, FetchErrF=1, InstrValidF=1 for one cycle.
REQ-036 PCF=0x42 -> imem_req=0, InstrF=32'h00000013, FetchErrF=1; reset pulled low during RSP -> all outputs return to REQ-029 values immediately.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: issues PC-addressed requests to instruction
// memory and presents one instruction at a time to the decode stage.
module imem_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        HoldF,
    input  logic        RedirectF,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        FetchStallF,
    output logic        FetchErrF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_RSP,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  dcnt;
    logic [1:0]  dcnt_nxt;
    logic [31:0] hold_instr;
    logic        hold_err;
    logic        hold_load;
    logic        stale;

    assign imem_addr   = PCF;
    assign FetchStallF = ~InstrValidF;
    assign stale       = imem_rvalid && (dcnt != 2'd0);

    // State, stale-response counter and held instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            dcnt       <= 2'd0;
            hold_instr <= NOP;
            hold_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (hold_load) begin
                hold_instr <= InstrF;
                hold_err   <= FetchErrF;
            end
        end
    end

    // Next state, discard bookkeeping and fetch-stage outputs.
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        imem_req    = 1'b0;
        InstrF      = NOP;
        InstrValidF = 1'b0;
        FetchErrF   = 1'b0;
        hold_load   = 1'b0;
        if (reset) begin
            if (stale) begin
                dcnt_nxt = dcnt - 2'd1;
            end
            unique case (state)
                S_REQ: begin
                    if (RedirectF) begin
                        state_nxt = S_REQ;
                    end else if (PCF[1:0] != 2'b00) begin
                        InstrValidF = 1'b1;
                        FetchErrF   = 1'b1;
                    end else if (dcnt != 2'd2) begin
                        imem_req = 1'b1;
                        if (imem_gnt) begin
                            state_nxt = S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (RedirectF) begin
                        // live request turns stale; a stale
                        // response this cycle cancels it out
                        state_nxt = S_REQ;
                        dcnt_nxt  = imem_rvalid ? dcnt
                                                : dcnt + 2'd1;
                    end else if (imem_rvalid && dcnt == 2'd0) begin
                        InstrValidF = 1'b1;
                        FetchErrF   = imem_err;
                        InstrF      = imem_err ? NOP : imem_rdata;
                        hold_load   = HoldF;
                        state_nxt   = HoldF ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (RedirectF) begin
                        state_nxt = S_REQ;
                    end else begin
                        InstrValidF = 1'b1;
                        InstrF      = hold_instr;
                        FetchErrF   = hold_err;
                        if (!HoldF) begin
                            state_nxt = S_REQ;
                        end
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

endmodule
